// File: rtl/spike_rate_meter_if.sv
// rtl/spike_rate_meter_if.sv - valid/ready result port carrying one window's spike count
interface spike_rate_meter_if #(
  parameter int CNT_W = 16
) ();
  logic [CNT_W-1:0] rate_count;
  logic             rate_sat;
  logic             rate_valid;
  logic             rate_ready;

  modport master (output rate_count, output rate_sat, output rate_valid, input rate_ready);
  modport slave  (input rate_count, input rate_sat, input rate_valid, output rate_ready);
endinterface

// File: rtl/spike_rate_meter.sv
// rtl/spike_rate_meter.sv - windowed spike counter with valid/ready result and ISI measurement
// Optional SPIKE_EDGE_EN: count only rising edges of spike_in instead of every high cycle.
module spike_rate_meter #(
  parameter int WINDOW = 1000,
  parameter int CNT_W  = 16,
  parameter int ISI_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 spike_in,
  spike_rate_meter_if.master   rate,
  output logic                 overrun,
  output logic [ISI_W-1:0]     last_isi,
  output logic                 isi_valid
);
  localparam int               WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d, spk_fin;
  logic             spk_sat_q, spk_sat_d, sat_fin;
  logic [CNT_W-1:0] rate_count_q, rate_count_d;
  logic             rate_sat_q, rate_sat_d;
  logic             rate_valid_q, rate_valid_d;
  logic             overrun_q, overrun_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d, isi_inc;
  logic [ISI_W-1:0] last_isi_q, last_isi_d;
  logic             isi_valid_q, isi_valid_d;
  logic             have_prev_q, have_prev_d;
  logic             qual, win_last;

  // COUNT is exactly the set of cycles with en high; the first such cycle is window cycle 0.
`ifdef SPIKE_EDGE_EN
  logic prev_q;
  assign qual = en & spike_in & ~prev_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= en & spike_in;
  end
`else
  assign qual = en & spike_in;
`endif

  always_comb begin
    win_last  = en && (win_cnt_q == WIN_LAST);
    win_cnt_d = (!en || win_last) ? '0 : win_cnt_q + WIN_W'(1);

    spk_fin = spk_cnt_q;
    sat_fin = spk_sat_q;
    if (qual) begin
      if (spk_cnt_q == CNT_MAX) sat_fin = 1'b1;
      else                      spk_fin = spk_cnt_q + CNT_W'(1);
    end
    spk_cnt_d = (!en || win_last) ? '0   : spk_fin;
    spk_sat_d = (!en || win_last) ? 1'b0 : sat_fin;

    rate_count_d = rate_count_q;
    rate_sat_d   = rate_sat_q;
    rate_valid_d = rate_valid_q;
    overrun_d    = overrun_q;
    if (rate_valid_q && rate.rate_ready) rate_valid_d = 1'b0;
    // A result that lands while the held one is not being taken is lost.
    if (win_last) begin
      if (!rate_valid_q || rate.rate_ready) begin
        rate_count_d = spk_fin;
        rate_sat_d   = sat_fin;
        rate_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    isi_inc     = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + ISI_W'(1);
    isi_cnt_d   = en ? isi_inc : '0;
    have_prev_d = en & have_prev_q;
    last_isi_d  = last_isi_q;
    isi_valid_d = 1'b0;
    if (qual) begin
      if (have_prev_q) begin
        last_isi_d  = isi_inc;
        isi_valid_d = 1'b1;
      end
      isi_cnt_d   = '0;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt_q    <= '0;
      spk_cnt_q    <= '0;
      spk_sat_q    <= 1'b0;
      rate_count_q <= '0;
      rate_sat_q   <= 1'b0;
      rate_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      isi_cnt_q    <= '0;
      last_isi_q   <= '0;
      isi_valid_q  <= 1'b0;
      have_prev_q  <= 1'b0;
    end else begin
      win_cnt_q    <= win_cnt_d;
      spk_cnt_q    <= spk_cnt_d;
      spk_sat_q    <= spk_sat_d;
      rate_count_q <= rate_count_d;
      rate_sat_q   <= rate_sat_d;
      rate_valid_q <= rate_valid_d;
      overrun_q    <= overrun_d;
      isi_cnt_q    <= isi_cnt_d;
      last_isi_q   <= last_isi_d;
      isi_valid_q  <= isi_valid_d;
      have_prev_q  <= have_prev_d;
    end
  end

  assign rate.rate_count = rate_count_q;
  assign rate.rate_sat   = rate_sat_q;
  assign rate.rate_valid = rate_valid_q;
  assign overrun         = overrun_q;
  assign last_isi        = last_isi_q;
  assign isi_valid       = isi_valid_q;
endmodule

// File: tb/tb_spike_rate_meter.sv
// tb/tb_spike_rate_meter.sv - directed checks of spike_rate_meter (WINDOW=10, CNT_W=4 and CNT_W=3)
module tb_spike_rate_meter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic spike = 1'b0;
  logic ready = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  spike_rate_meter_if #(.CNT_W(4)) ra ();
  spike_rate_meter_if #(.CNT_W(3)) rb ();
  logic       ovr_a, ovr_b, isiv_a, isiv_b;
  logic [3:0] isi_a, isi_b;

  assign ra.rate_ready = ready;
  assign rb.rate_ready = ready;

  spike_rate_meter #(.WINDOW(10), .CNT_W(4), .ISI_W(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike), .rate(ra.master),
    .overrun(ovr_a), .last_isi(isi_a), .isi_valid(isiv_a));

  spike_rate_meter #(.WINDOW(10), .CNT_W(3), .ISI_W(4)) u_b (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike), .rate(rb.master),
    .overrun(ovr_b), .last_isi(isi_b), .isi_valid(isiv_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input logic s);
    spike = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1'b0);
    step(1'b0);
    chk("rst_valid", 32'(ra.rate_valid), 0);
    chk("rst_count", 32'(ra.rate_count), 0);
    chk("rst_isi", 32'(isi_a), 0);
    chk("rst_ovr", 32'(ovr_a), 0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0);

    // spikes on 0,3,6,9
    en = 1'b1;
    ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(c % 3 == 0);
      if (c == 0 || c == 4) chk("t1_isiv_lo", 32'(isiv_a), 0);
      if (c == 3 || c == 6 || c == 9) begin
        chk("t1_isiv", 32'(isiv_a), 1);
        chk("t1_isi", 32'(isi_a), 3);
      end
      if (c == 8) chk("t1_valid_early", 32'(ra.rate_valid), 0);
    end
    chk("t1_valid", 32'(ra.rate_valid), 1);
    chk("t1_count", 32'(ra.rate_count), 4);
    chk("t1_sat", 32'(ra.rate_sat), 0);
    chk("t1_count_b", 32'(rb.rate_count), 4);
    step(1'b0);
    chk("t1_valid_pulse", 32'(ra.rate_valid), 0);

    // spike held high
    en = 1'b0;
    step(1'b0);
    en = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1);
`ifdef SPIKE_EDGE_EN
    chk("t2_count_w1", 32'(ra.rate_count), 1);
    chk("t3_count_b", 32'(rb.rate_count), 1);
    chk("t3_sat_b", 32'(rb.rate_sat), 0);
`else
    chk("t2_count_w1", 32'(ra.rate_count), 10);
    chk("t3_count_b", 32'(rb.rate_count), 7);
    chk("t3_sat_b", 32'(rb.rate_sat), 1);
`endif
    chk("t2_sat_a", 32'(ra.rate_sat), 0);
    for (int i = 0; i < 10; i++) step(1'b1);
`ifdef SPIKE_EDGE_EN
    chk("t2_count_w2", 32'(ra.rate_count), 0);
`else
    chk("t2_count_w2", 32'(ra.rate_count), 10);
`endif
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("t3_quiet_count", 32'(rb.rate_count), 0);
    chk("t3_quiet_sat", 32'(rb.rate_sat), 0);

    // overrun with ready low across two window ends
    en = 1'b0;
    step(1'b0);
    en = 1'b1;
    ready = 1'b0;
    for (int c = 0; c < 10; c++) step(c == 1 || c == 4);
    chk("t4_valid_w1", 32'(ra.rate_valid), 1);
    chk("t4_count_w1", 32'(ra.rate_count), 2);
    chk("t4_ovr_w1", 32'(ovr_a), 0);
    for (int c = 0; c < 10; c++) step(c % 2 == 0);
    chk("t4_valid_w2", 32'(ra.rate_valid), 1);
    chk("t4_count_held", 32'(ra.rate_count), 2);
    chk("t4_ovr_w2", 32'(ovr_a), 1);
    ready = 1'b1;
    en = 1'b0;
    step(1'b0);
    chk("t4_drained", 32'(ra.rate_valid), 0);
    chk("t4_ovr_sticky", 32'(ovr_a), 1);

    // partial window dropped by en low
    en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(c == 1 || c == 3);
      if (c == 3) chk("t6_isi_pre", 32'(isi_a), 2);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("t6_no_partial", 32'(ra.rate_valid), 0);
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(c == 2 || c == 5);
      if (c == 2) begin
        chk("t6_first_isiv", 32'(isiv_a), 0);
        chk("t6_isi_held", 32'(isi_a), 2);
      end
      if (c == 5) begin
        chk("t6_isiv", 32'(isiv_a), 1);
        chk("t6_isi", 32'(isi_a), 3);
      end
      if (c == 8) chk("t6_valid_early", 32'(ra.rate_valid), 0);
    end
    chk("t6_valid", 32'(ra.rate_valid), 1);
    chk("t6_count", 32'(ra.rate_count), 2);
    ready = 1'b0;
    for (int c = 0; c < 3; c++) step(1'b0);

    // asynchronous reset, checked before any clock edge
    #1;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(ra.rate_valid), 0);
    chk("arst_count", 32'(ra.rate_count), 0);
    chk("arst_isi", 32'(isi_a), 0);
    chk("arst_ovr", 32'(ovr_a), 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0);

    // ready arrives on the window-end cycle of the second window
    en = 1'b1;
    for (int c = 0; c < 10; c++) step(c == 2);
    chk("t5_valid_w1", 32'(ra.rate_valid), 1);
    chk("t5_count_w1", 32'(ra.rate_count), 1);
    for (int c = 0; c < 10; c++) begin
      ready = (c == 9);
      step(c == 1 || c == 3 || c == 5);
      if (c == 8) chk("t5_count_stable", 32'(ra.rate_count), 1);
    end
    chk("t5_valid_kept", 32'(ra.rate_valid), 1);
    chk("t5_count_new", 32'(ra.rate_count), 3);
    chk("t5_ovr", 32'(ovr_a), 0);
    step(1'b0);
    chk("t5_drained", 32'(ra.rate_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
